// File: rtl/joint_pkg.sv
// Shared definitions for the joint step/dir generators.
//
// Contents:
//   MaxWidth        widest command/position width the helpers support
//   joint_state_e   sequencing states of a step generator
//   period_clamp()  saturating |cmd| clamped into [min_period, max_mag]
package joint_pkg;

    localparam int unsigned MaxWidth = 64;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StLow,
        StHold
    } joint_state_e;

    // Callers sign-extend their command to MaxWidth. Taking the magnitude at
    // 64 bits cannot overflow, and max_mag folds the most negative
    // WIDTH-bit command back to the largest positive WIDTH-bit period.
    function automatic logic [MaxWidth-1:0] period_clamp(
        input logic signed [MaxWidth-1:0] cmd,
        input logic        [MaxWidth-1:0] max_mag,
        input logic        [MaxWidth-1:0] min_period
    );
        logic [MaxWidth-1:0] mag;
        mag = cmd[MaxWidth-1] ? unsigned'(-cmd) : unsigned'(cmd);
        if (mag > max_mag) begin
            mag = max_mag;
        end
        if (mag < min_period) begin
            mag = min_period;
        end
        return mag;
    endfunction

endpackage

// File: rtl/joint_period_timer.sv
// Loadable down-counter with a terminal-count flag.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset (count cleared to 0)
//   load      load load_val this cycle (wins over counting)
//   load_val  value to load
//   done      count has reached 0; the counter holds there until reloaded
//
// Loading N gives done in the (N+1)-th cycle after the load edge, so callers
// load "cycles - 1".
module joint_period_timer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/joint_stepper_gen.sv
// Step/dir pulse generator for one machine joint.
//
// Parameters:
//   WIDTH      width of jointFreqCmd and jointPosition (<= 64)
//   PULSE_LEN  STP high time in clk cycles (>= 1)
//   DIR_SETUP  cycles DIR is stable before an STP rising edge (>= 1)
//   DIR_HOLD   cycles DIR is stable after an STP falling edge (>= 0)
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   jointEnable    1 = generate steps, 0 = stop after any pulse in flight
//   jointFreqCmd   signed period command; |cmd| = period, sign = direction, 0 = stop
//   DIR            direction pin, 1 = forward
//   STP            step pin, active high
//   jointPosition  signed count of issued steps, wraps two's complement
//   busy           high whenever the sequencer is not idle
//
// One period timer measures rising edge to rising edge. A second phase timer
// is reused for the DIR setup count, the STP high time, and the DIR hold count
// (the hold count starts at the falling edge and runs through LOW).
module joint_stepper_gen
    import joint_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned PULSE_LEN = 50,
    parameter int unsigned DIR_SETUP = 100,
    parameter int unsigned DIR_HOLD  = 100
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    jointEnable,
    input  logic signed [WIDTH-1:0] jointFreqCmd,
    output logic                    DIR,
    output logic                    STP,
    output logic signed [WIDTH-1:0] jointPosition,
    output logic                    busy
);

    localparam logic [MaxWidth-1:0] MaxMag    = (MaxWidth'(1) << (WIDTH - 1)) - MaxWidth'(1);
    localparam logic [MaxWidth-1:0] MinPeriod = MaxWidth'(PULSE_LEN) + MaxWidth'(1);
    localparam logic [WIDTH-1:0]    PulseLoad = WIDTH'(PULSE_LEN - 1);
    localparam logic [WIDTH-1:0]    SetupLoad = WIDTH'(DIR_SETUP - 1);
    localparam logic [WIDTH-1:0]    HoldLoad  = (DIR_HOLD == 0) ? '0 : WIDTH'(DIR_HOLD - 1);

    joint_state_e state_q, state_d;
    logic         dir_q, dir_d;
    logic [WIDTH-1:0] pos_q, pos_d;

    logic signed [MaxWidth-1:0] cmd_ext;
    logic [WIDTH-1:0] period_m1;
    logic             run_req;
    logic             req_fwd;
    logic             enter_pulse;
    logic             per_load;
    logic             per_done;
    logic             ph_load;
    logic [WIDTH-1:0] ph_val;
    logic             ph_done;

    // Effective period minus one, ready to load into the period timer.
    assign cmd_ext   = MaxWidth'(jointFreqCmd);
    assign period_m1 = WIDTH'(period_clamp(cmd_ext, MaxMag, MinPeriod) - MaxWidth'(1));

    assign run_req = jointEnable && (jointFreqCmd != '0);
    assign req_fwd = !jointFreqCmd[WIDTH-1];

    joint_period_timer #(
        .WIDTH (WIDTH)
    ) u_period_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (per_load),
        .load_val (period_m1),
        .done     (per_done)
    );

    joint_period_timer #(
        .WIDTH (WIDTH)
    ) u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ph_load),
        .load_val (ph_val),
        .done     (ph_done)
    );

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        pos_d       = pos_q;
        per_load    = 1'b0;
        ph_load     = 1'b0;
        ph_val      = PulseLoad;
        enter_pulse = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run_req) begin
                    if (req_fwd == dir_q) begin
                        enter_pulse = 1'b1;
                    end else begin
                        // DIR moves here; the setup count starts with it.
                        dir_d   = req_fwd;
                        ph_load = 1'b1;
                        ph_val  = SetupLoad;
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                if (ph_done) begin
                    enter_pulse = 1'b1;
                end
            end
            StPulse: begin
                if (ph_done) begin
                    // Falling edge: the hold count runs concurrently with LOW.
                    ph_load = 1'b1;
                    ph_val  = HoldLoad;
                    state_d = StLow;
                end
            end
            StLow: begin
                if (per_done) begin
                    if (run_req && (req_fwd == dir_q)) begin
                        enter_pulse = 1'b1;
                    end else if (ph_done) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (ph_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Every way into PULSE latches the period and counts the step.
        if (enter_pulse) begin
            state_d  = StPulse;
            per_load = 1'b1;
            ph_load  = 1'b1;
            ph_val   = PulseLoad;
            pos_d    = dir_q ? (pos_q + WIDTH'(1)) : (pos_q - WIDTH'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            dir_q   <= 1'b0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
        end
    end

    // STP decodes straight from the state register so reset clears it at once.
    assign STP           = (state_q == StPulse);
    assign busy          = (state_q != StIdle);
    assign DIR           = dir_q;
    assign jointPosition = signed'(pos_q);

endmodule
